// File: rtl/shift_cmd_pkg.sv
// Shared mode encodings and mode FSM state type for the shift-register stage.
package shift_cmd_pkg;

  localparam logic [1:0] CTRL_HOLD  = 2'b00;
  localparam logic [1:0] CTRL_LOAD  = 2'b11;
  localparam logic [1:0] CTRL_LEFT  = 2'b01;
  localparam logic [1:0] CTRL_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    ST_HOLD  = CTRL_HOLD,
    ST_LOAD  = CTRL_LOAD,
    ST_LEFT  = CTRL_LEFT,
    ST_RIGHT = CTRL_RIGHT
  } mode_state_t;

  // Mode sequence advanced by each mode press.
  function automatic mode_state_t next_mode(input mode_state_t cur);
    case (cur)
      ST_HOLD:  return ST_LOAD;
      ST_LOAD:  return ST_LEFT;
      ST_LEFT:  return ST_RIGHT;
      default:  return ST_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/shift_cmd_gen_btn_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter, press pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // Level flips after DB_CYCLES consecutive mismatches; press marks a 0->1 flip.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 != level) begin
        if (cnt == CNT_LAST) begin
          cnt   <= '0;
          level <= sync_2;
          press <= sync_2;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/shift_cmd_gen.sv
// Front-panel command generator: mode FSM, manual/auto step strobe, serial-in bit.
module shift_cmd_gen
  import shift_cmd_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = 2_000_000,
  parameter int unsigned AUTO_PERIOD = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_step,
  input  logic       btn_run,
  input  logic       sw_shift,
  output logic [1:0] ctrl,
  output logic       shift,
  output logic       step,
  output logic       run
);

  localparam int unsigned TW = $clog2(AUTO_PERIOD);
  localparam logic [TW-1:0] TICK_LAST = TW'(AUTO_PERIOD - 1);

  logic          mode_press;
  logic          step_press;
  logic          run_press;
  logic [2:0]    levels_unused;
  logic          sw_sync_1;
  logic          sw_sync_2;
  logic [TW-1:0] tick;
  mode_state_t   state;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_mode),
    .level(levels_unused[0]), .press(mode_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_step),
    .level(levels_unused[1]), .press(step_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_run),
    .level(levels_unused[2]), .press(run_press)
  );

  // State register doubles as the registered mode code.
  assign ctrl = state;

  // Mode FSM, run toggle, tick counter, step strobe and serial-in sync.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_HOLD;
      run       <= 1'b0;
      tick      <= '0;
      step      <= 1'b0;
      sw_sync_1 <= 1'b0;
      sw_sync_2 <= 1'b0;
      shift     <= 1'b0;
    end else begin
      sw_sync_1 <= sw_shift;
      sw_sync_2 <= sw_sync_1;
      shift     <= sw_sync_2;

      if (mode_press) begin
        state <= next_mode(state);
      end

      step <= 1'b0;
      if (run_press) begin
        // Entering run still honours a coincident step press; leaving drops it.
        run  <= ~run;
        tick <= '0;
        if (!run) begin
          step <= step_press;
        end
      end else if (run) begin
        if (tick == TICK_LAST) begin
          tick <= '0;
          step <= 1'b1;
        end else begin
          tick <= tick + TW'(1);
        end
      end else begin
        step <= step_press;
      end
    end
  end

endmodule

// File: tb/tb_shift_cmd_gen.sv
// Directed bench for shift_cmd_gen with DB_CYCLES=4, AUTO_PERIOD=10.
module tb_shift_cmd_gen;

  localparam int unsigned DB = 4;
  localparam int unsigned AP = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_run = 1'b0;
  logic       sw_shift = 1'b0;
  logic [1:0] ctrl;
  logic       shift;
  logic       step;
  logic       run;

  int n_cmp = 0;
  int n_err = 0;
  int step_cnt = 0;

  typedef struct {
    logic       m;
    logic       s;
    logic       sw;
    int         ncyc;
    logic [1:0] exp_ctrl;
    int         exp_steps;
    logic       exp_shift;
  } vec_t;

  vec_t vecs[7];

  shift_cmd_gen #(.DB_CYCLES(DB), .AUTO_PERIOD(AP)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_step(btn_step),
    .btn_run(btn_run), .sw_shift(sw_shift), .ctrl(ctrl), .shift(shift),
    .step(step), .run(run)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step) step_cnt <= step_cnt + 1;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_step(output int lat);
    bit found = 0;
    lat = -1;
    for (int k = 1; k <= 40 && !found; k++) begin
      cyc(1);
      if (step) begin
        lat = k;
        found = 1;
      end
    end
  endtask

  task automatic wait_ctrl_change(input logic [1:0] prev, output int lat);
    bit found = 0;
    lat = -1;
    for (int k = 1; k <= 40 && !found; k++) begin
      cyc(1);
      if (ctrl != prev) begin
        lat = k;
        found = 1;
      end
    end
  endtask

  task automatic wait_run(input logic val, output int lat);
    bit found = 0;
    lat = -1;
    for (int k = 1; k <= 40 && !found; k++) begin
      cyc(1);
      if (run == val) begin
        lat = k;
        found = 1;
      end
    end
  endtask

  initial begin
    int lat;
    int snap;
    logic [1:0] prev;
    logic [1:0] mode_seq [4];

    mode_seq[0] = 2'b11; mode_seq[1] = 2'b01; mode_seq[2] = 2'b10; mode_seq[3] = 2'b00;

    // Segments starting from LOAD with all buttons released.
    vecs[0] = '{m:1'b0, s:1'b0, sw:1'b1, ncyc:3,  exp_ctrl:2'b11, exp_steps:0, exp_shift:1'b1};
    vecs[1] = '{m:1'b0, s:1'b0, sw:1'b0, ncyc:2,  exp_ctrl:2'b11, exp_steps:0, exp_shift:1'b1};
    vecs[2] = '{m:1'b0, s:1'b0, sw:1'b0, ncyc:1,  exp_ctrl:2'b11, exp_steps:0, exp_shift:1'b0};
    vecs[3] = '{m:1'b1, s:1'b0, sw:1'b0, ncyc:10, exp_ctrl:2'b01, exp_steps:0, exp_shift:1'b0};
    vecs[4] = '{m:1'b0, s:1'b0, sw:1'b0, ncyc:10, exp_ctrl:2'b01, exp_steps:0, exp_shift:1'b0};
    vecs[5] = '{m:1'b0, s:1'b1, sw:1'b1, ncyc:10, exp_ctrl:2'b01, exp_steps:1, exp_shift:1'b1};
    vecs[6] = '{m:1'b0, s:1'b0, sw:1'b1, ncyc:10, exp_ctrl:2'b01, exp_steps:0, exp_shift:1'b1};

    // Reset with btn_step held through release.
    btn_step = 1'b1;
    cyc(3);
    check("rst_ctrl", int'(ctrl), 0);
    check("rst_shift", int'(shift), 0);
    check("rst_step", int'(step), 0);
    check("rst_run", int'(run), 0);
    snap = step_cnt;
    rst_n = 1'b1;
    wait_step(lat);
    check("held_step_latency", lat, 7);
    cyc(10);
    btn_step = 1'b0;
    cyc(12);
    check("held_step_count", step_cnt - snap, 1);

    // Bouncing step button.
    snap = step_cnt;
    for (int b = 0; b < 4; b++) begin
      btn_step = (b % 2 == 0);
      cyc(2);
    end
    btn_step = 1'b1;
    cyc(8);
    check("bounce_step_count", step_cnt - snap, 1);
    btn_step = 1'b0;
    cyc(12);
    check("release_step_count", step_cnt - snap, 1);

    // Four clean mode presses.
    snap = step_cnt;
    for (int i = 0; i < 4; i++) begin
      prev = ctrl;
      btn_mode = 1'b1;
      wait_ctrl_change(prev, lat);
      check($sformatf("mode%0d_latency", i), lat, 7);
      check($sformatf("mode%0d_ctrl", i), int'(ctrl), int'(mode_seq[i]));
      cyc(3);
      btn_mode = 1'b0;
      cyc(10);
    end
    check("mode_no_step", step_cnt - snap, 0);

    // Auto-run.
    btn_run = 1'b1;
    wait_run(1'b1, lat);
    check("run_on_latency", lat, 7);
    btn_run = 1'b0;
    for (int p = 0; p < 3; p++) begin
      wait_step(lat);
      check($sformatf("auto_step%0d_spacing", p), lat, int'(AP));
    end
    snap = step_cnt;
    btn_step = 1'b1;
    cyc(10);
    btn_step = 1'b0;
    cyc(10);
    check("run_step_ignored", step_cnt - snap, 2);
    btn_run = 1'b1;
    wait_run(1'b0, lat);
    check("run_off_latency", lat, 7);
    btn_run = 1'b0;
    snap = step_cnt;
    cyc(30);
    check("run_off_no_step", step_cnt - snap, 0);

    // Simultaneous mode and step press from HOLD.
    btn_mode = 1'b1;
    btn_step = 1'b1;
    wait_ctrl_change(2'b00, lat);
    check("simul_latency", lat, 7);
    check("simul_ctrl", int'(ctrl), 3);
    check("simul_step", int'(step), 1);
    cyc(3);
    btn_mode = 1'b0;
    btn_step = 1'b0;
    cyc(10);

    // Table of segments.
    for (int v = 0; v < 7; v++) begin
      btn_mode = vecs[v].m;
      btn_step = vecs[v].s;
      sw_shift = vecs[v].sw;
      snap = step_cnt;
      cyc(vecs[v].ncyc);
      check($sformatf("vec%0d_ctrl", v), int'(ctrl), int'(vecs[v].exp_ctrl));
      check($sformatf("vec%0d_steps", v), step_cnt - snap, vecs[v].exp_steps);
      check($sformatf("vec%0d_shift", v), int'(shift), int'(vecs[v].exp_shift));
    end
    btn_mode = 1'b0;
    btn_step = 1'b0;

    // Reset in the middle of an auto-run count.
    btn_run = 1'b1;
    wait_run(1'b1, lat);
    check("run2_on_latency", lat, 7);
    btn_run = 1'b0;
    cyc(5);
    check("pre_rst_shift", int'(shift), 1);
    rst_n = 1'b0;
    cyc(1);
    check("midrst_ctrl", int'(ctrl), 0);
    check("midrst_shift", int'(shift), 0);
    check("midrst_step", int'(step), 0);
    check("midrst_run", int'(run), 0);
    rst_n = 1'b1;
    sw_shift = 1'b0;
    snap = step_cnt;
    cyc(15);
    check("post_rst_no_step", step_cnt - snap, 0);
    check("post_rst_run", int'(run), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
